// File: rtl/conv3x3_window_mac.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_window_mac
//  Description : 3x3 sliding-window multiply-accumulate over a raster pixel
//                stream. Two line buffers feed a 3x3 window that is
//                multiplied by a loadable signed kernel; one signed sum is
//                emitted per complete window position.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_window_mac #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 16,
  parameter int ACC_W  = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               cfg_width,
  input  logic [4:0]               cfg_height,
  input  logic                     k_wr_en,
  input  logic [3:0]               k_addr,
  input  logic signed [DATA_W-1:0] k_data,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  localparam int         c_LB_AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [5:0] c_MAX_W = 6'(MAX_W);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]               r_state;
  logic [4:0]               r_w;
  logic [4:0]               r_h;
  logic [4:0]               r_row;
  logic [4:0]               r_col;
  logic                     r_cfg_err;
  logic                     r_out_valid;
  logic signed [ACC_W-1:0]  r_out_data;
  logic signed [DATA_W-1:0] r_kernel [9];
  logic [DATA_W-1:0]        r_win    [3][3];
  logic [DATA_W-1:0]        r_lb0    [MAX_W];
  logic [DATA_W-1:0]        r_lb1    [MAX_W];

  logic                     w_cfg_ok;
  logic                     w_accept;
  logic                     w_col_last;
  logic                     w_last_pix;
  logic                     w_win_full;
  logic [c_LB_AW-1:0]       w_cidx;
  logic [DATA_W-1:0]        w_lb0_rd;
  logic [DATA_W-1:0]        w_lb1_rd;
  logic [DATA_W-1:0]        w_tap [9];
  logic signed [ACC_W-1:0]  w_sum;

  // A start is only honoured for a frame that yields at least one window
  assign w_cfg_ok   = (cfg_width >= 5'd3) && ({1'b0, cfg_width} <= c_MAX_W) &&
                      (cfg_height >= 5'd3);
  // Back-pressure: stall input only when a result is stuck at the output
  assign in_ready   = (r_state == c_RUN) && !(r_out_valid && !out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_col_last = (r_col == r_w - 5'd1);
  assign w_last_pix = w_col_last && (r_row == r_h - 5'd1);
  assign w_win_full = (r_row >= 5'd2) && (r_col >= 5'd2);
  assign w_cidx     = r_col[c_LB_AW-1:0];
  assign w_lb0_rd   = r_lb0[w_cidx];
  assign w_lb1_rd   = r_lb1[w_cidx];

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = (r_state == c_RUN) || (r_state == c_DRAIN);
  assign done       = (r_state == c_DONE);
  assign cfg_err    = r_cfg_err;

  // Window taps as they will look after this pixel shifts in (row 0 oldest)
  always_comb begin
    w_tap = '{default: '0};
    for (int r = 0; r < 3; r++) begin
      w_tap[3*r]     = r_win[r][1];
      w_tap[3*r + 1] = r_win[r][2];
    end
    w_tap[2] = w_lb1_rd;
    w_tap[5] = w_lb0_rd;
    w_tap[8] = in_data;
  end

  // Nine signed products of zero-extended pixels and kernel coefficients
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 9; i++) begin
      w_sum = w_sum + ACC_W'($signed({1'b0, w_tap[i]})) * ACC_W'(r_kernel[i]);
    end
  end

  // Frame control: state, latched geometry, raster counters, config error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_w       <= '0;
      r_h       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_w     <= cfg_width;
              r_h     <= cfg_height;
              r_row   <= '0;
              r_col   <= '0;
              r_state <= c_RUN;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        c_RUN: begin
          if (w_accept) begin
            if (w_col_last) begin
              r_col <= '0;
              r_row <= r_row + 5'd1;
            end else begin
              r_col <= r_col + 5'd1;
            end
            if (w_last_pix) r_state <= c_DRAIN;
          end
        end
        c_DRAIN: begin
          if (!r_out_valid) r_state <= c_DONE;
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Kernel coefficients are writable only while idle; out-of-range index dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_kernel[i] <= '0;
    end else if ((r_state == c_IDLE) && k_wr_en && (k_addr <= 4'd8)) begin
      r_kernel[k_addr] <= k_data;
    end
  end

  // Window shift and line-buffer rotation on every accepted pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
      end
      for (int i = 0; i < MAX_W; i++) begin
        r_lb0[i] <= '0;
        r_lb1[i] <= '0;
      end
    end else if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2]   <= w_lb1_rd;
      r_win[1][2]   <= w_lb0_rd;
      r_win[2][2]   <= in_data;
      r_lb1[w_cidx] <= w_lb0_rd;
      r_lb0[w_cidx] <= in_data;
    end
  end

  // Result register: load on a completed window, release on downstream accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept && w_win_full) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sum;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_window_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv3x3_window_mac
//  Description : Self-checking bench for conv3x3_window_mac. A direct 2-D
//                convolution of each frame provides the expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_window_mac;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        cfg_width;
  logic [4:0]        cfg_height;
  logic              k_wr_en;
  logic [3:0]        k_addr;
  logic signed [7:0] k_data;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              out_valid;
  logic signed [20:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  int km [9];
  int exp_q [$];

  conv3x3_window_mac #(.DATA_W(8), .MAX_W(16), .ACC_W(21)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .k_wr_en    (k_wr_en),
    .k_addr     (k_addr),
    .k_data     (k_data),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_kernel(input int k [9]);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      k_wr_en = 1'b1;
      k_addr  = 4'(i);
      k_data  = 8'(k[i]);
      km[i]   = k[i];
    end
    // index beyond 8 must be dropped
    @(negedge clk);
    k_addr = 4'($urandom_range(15, 9));
    k_data = 8'($urandom);
    @(negedge clk);
    k_wr_en = 1'b0;
  endtask

  // Stream one frame, compare every handshaken result against the model
  task automatic run_frame(input int w, input int h, input int mode,
                           input int vprob, input int rprob,
                           input int stall, input bit noise);
    int n, n_exp, p, got, cyc, ndone, stall_left, s;
    int pix [];
    logic seen_valid, prev_stall, rdy_chk;
    logic signed [20:0] prev_data;
    n   = w * h;
    pix = new[n];
    for (int i = 0; i < n; i++)
      pix[i] = (mode == 0) ? (i % 256) : (mode == 1) ? int'($urandom_range(255)) : 255;
    exp_q.delete();
    for (int r = 0; r + 2 < h; r++)
      for (int c = 0; c + 2 < w; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += km[3*i + j] * pix[(r + i) * w + c + j];
        exp_q.push_back(s);
      end
    n_exp = exp_q.size();

    @(negedge clk);
    cfg_width  = 5'(w);
    cfg_height = 5'(h);
    start      = 1'b1;
    p = 0; got = 0; cyc = 0; ndone = 0; stall_left = stall;
    seen_valid = 1'b0; prev_stall = 1'b0; rdy_chk = 1'b0; prev_data = '0;
    while (ndone == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start    = noise ? 1'($urandom_range(1)) : 1'b0;
      in_valid = (p < n) && ($urandom_range(99) < vprob);
      in_data  = (p < n) ? 8'(pix[p]) : 8'($urandom);
      if (out_valid) seen_valid = 1'b1;
      if (seen_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) < rprob);
      end
      if (noise) begin
        k_wr_en = 1'($urandom_range(1));
        k_addr  = 4'($urandom_range(8));
        k_data  = 8'($urandom);
      end
      #1;
      if (p == n && !rdy_chk) begin
        chk("rdy_after_last", in_ready, 0);
        rdy_chk = 1'b1;
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (noise) chk("cfg_err_run", cfg_err, 0);
      if (out_valid && out_ready) begin
        got++;
        if (exp_q.size() == 0) chk("extra_out", got, n_exp);
        else                   chk("out_data", out_data, exp_q.pop_front());
      end
      if (done) begin
        ndone++;
        chk("busy_at_done", busy, 0);
      end else begin
        chk("busy_run", busy, 1);
      end
      if (in_valid && in_ready) p++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    start   = 1'b0;
    k_wr_en = 1'b0;
    in_valid = 1'b0;
    chk("frame_done", ndone, 1);
    chk("pixels_taken", p, n);
    chk("result_count", got, n_exp);
    @(negedge clk);
    #1;
    chk("done_pulse_end", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
  endtask

  task automatic try_bad(input int w, input int h);
    @(negedge clk);
    cfg_width  = 5'(w);
    cfg_height = 5'(h);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("cfg_err_clear", cfg_err, 0);
    chk("cfg_err_idle", busy, 0);
  endtask

  // Reset in the middle of a 4x4 frame after npix accepted pixels
  task automatic reset_mid(input int npix, input bit ordy);
    int p, cyc;
    p = 0; cyc = 0;
    @(negedge clk);
    cfg_width = 5'd4; cfg_height = 5'd4; start = 1'b1;
    while (p < npix && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; in_valid = 1'b1; in_data = 8'(p); out_ready = ordy;
      #1;
      if (in_ready) p++;
    end
    chk("pre_rst_pixels", p, npix);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_busy", busy, 1);
    if (!ordy) chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) km[i] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kc [9];
    int w, h;
    rst = 1'b1; cfg_width = '0; cfg_height = '0; k_wr_en = 1'b0; k_addr = '0;
    k_data = '0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int i = 0; i < 9; i++) km[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready0", in_ready, 0);
    chk("rst_out_valid0", out_valid, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_cfg_err0", cfg_err, 0);
    chk("rst_out_data0", out_data, 0);
    rst = 1'b0;

    // Identity-centre kernel over a ramp
    kc = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    load_kernel(kc);
    run_frame(4, 4, 0, 100, 100, 0, 1'b0);

    // All-ones kernel, saturated 3x3 frame
    kc = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    load_kernel(kc);
    run_frame(3, 3, 2, 100, 100, 0, 1'b0);

    // Most negative coefficients with full-scale pixels
    kc = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    load_kernel(kc);
    run_frame(3, 3, 2, 100, 100, 0, 1'b0);

    // Output stall right after the first result
    kc = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    load_kernel(kc);
    run_frame(5, 4, 0, 100, 100, 10, 1'b0);

    // Rejected configurations, then a fresh kernel and in-run write noise
    try_bad(2, 4);
    try_bad(17, 4);
    try_bad(4, 2);
    for (int i = 0; i < 9; i++) kc[i] = int'($urandom_range(255)) - 128;
    load_kernel(kc);
    run_frame(6, 5, 1, 70, 70, 0, 1'b1);

    // Mid-frame resets: the kernel must come back zeroed
    reset_mid(7, 1'b1);
    run_frame(4, 4, 1, 100, 100, 0, 1'b0);
    reset_mid(11, 1'b0);
    run_frame(4, 4, 1, 80, 80, 0, 1'b0);
    kc = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    load_kernel(kc);
    run_frame(4, 4, 0, 100, 100, 0, 1'b0);

    // Randomised frames, including full-width rows
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 9; i++) kc[i] = int'($urandom_range(255)) - 128;
      load_kernel(kc);
      w = (t == 0) ? 16 : int'($urandom_range(16, 3));
      h = int'($urandom_range(8, 3));
      run_frame(w, h, 1, int'($urandom_range(100, 40)), int'($urandom_range(100, 40)),
                int'($urandom_range(4)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
